bist_signature_analyzer: RTL
============================

// Module: bist_signature_analyzer
// PURPOSE
//  Downstream consumer of the BIST controller's control outputs (init, mode, running, finish).
//  Compacts the scan-out stream of the circuit under test into a multiple-input signature
//  register (MISR) during scan-shift cycles, then compares the result against a golden signature.
//  Holds pass/fail until the next init or reset.
// PARAMETERS
//  WIDTH      16       MISR width in bits (>= SCAN_W, >= 2)
//  SCAN_W     1        number of parallel scan-out bits compacted per cycle
//  POLY       16'h1021 feedback taps, x^WIDTH term implicit; bit i = tap on x^i
//  SEED       0        MISR value loaded on init
//  GOLDEN     16'h0000 expected final signature
//  EXP_CYC    0        expected number of compaction cycles; 0 = count not checked
//  CNT_W      16       width of compaction cycle counter
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  init        in   1       controller init: seed MISR, clear count/result
//  mode        in   1       controller scan-enable; 1 = shift cycle
//  running     in   1       controller running flag
//  finish      in   1       controller finish pulse: trigger compare
//  scan_out    in   SCAN_W  scan-chain outputs from CUT
//  signature   out  WIDTH   current MISR contents
//  cycle_cnt   out  CNT_W   compaction cycles since last init (saturating)
//  busy        out  1       high in ARMED
//  result_vld  out  1       high in RESULT
//  pass        out  1       valid when result_vld
//  fail        out  1       valid when result_vld; never high together with pass
// BEHAVIOUR
//  Interface: reset reset, synchronous, active-high; clock clock.
//  Reset: state=IDLE; signature=SEED; cycle_cnt=0; busy=result_vld=pass=fail=0.
//    Reset overrides all other inputs, including mid-compaction.
//  FSM: IDLE, ARMED, RESULT. All outputs are registered.
//  Priority per edge (highest first): reset > init > finish > compaction.
//  init=1 in any state -> next state ARMED; signature<=SEED; cycle_cnt<=0; pass=fail=0.
//    No compaction occurs on the init cycle.
//  ARMED, compaction cycle (running=1 and mode=1, finish=0):
//    signature <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ zero-extended scan_out.
//    cycle_cnt <= cycle_cnt+1, saturating at all-ones.
//  ARMED, running=1 and mode=0 (capture cycle): signature and count hold.
//  ARMED, finish=1 -> RESULT at next edge.
//    pass <= (signature==GOLDEN) && (EXP_CYC==0 || cycle_cnt==EXP_CYC); fail <= !pass.
//    Compare uses the register values at that edge; scan_out on the finish cycle is ignored.
//    Latency: finish at edge t -> result_vld/pass/fail valid after edge t.
//  IDLE or RESULT: running, mode, finish and scan_out are ignored; all outputs hold.
//    finish in IDLE does not produce a result.
//  RESULT persists until init or reset. A repeated finish does not re-compare.
//  Wrap-around: MISR wraps naturally. cycle_cnt saturates, so an overflowed run fails when EXP_CYC!=0.
// TESTING  (WIDTH=4, SCAN_W=1, POLY=4'h3, SEED=0 unless stated)
//  1. Reset, then init; shift scan_out 1,0,1,1 with running=mode=1; then finish.
//     -> signature 1,2,5,B; cycle_cnt=4. With GOLDEN=4'hB: pass=1, fail=0, one cycle after finish.
//  2. Same as test 1, plus one more shift with scan_out=0 (feedback from MSB).
//     -> signature 4'h5; with GOLDEN=4'hB: fail=1.
//  3. Capture cycles (running=1, mode=0) interleaved in test 1 -> identical signature and count.
//  4. EXP_CYC=3, run test 1 (4 cycles) -> signature matches but fail=1.
//  5. finish in IDLE, then init and finish in the same cycle -> no result; state ARMED, result_vld=0.
//  6. Reset asserted after 2 shifts -> signature=SEED, cycle_cnt=0, IDLE.
//     A later finish without init gives no result.

Source files
------------

// File: rtl/bist_signature_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : bist_signature_analyzer
// Purpose  : Compacts the CUT scan-out stream into a MISR during scan-shift
//            cycles signalled by the BIST controller. On the controller's
//            finish pulse it compares the signature (and optionally the
//            compaction cycle count) against golden values. The pass/fail
//            verdict is held until the next init or reset.
// Ports    : clock      - rising-edge clock
//            reset      - synchronous, active-high reset
//            init       - seed MISR, clear count and verdict, arm
//            mode       - controller scan-enable (1 = shift cycle)
//            running    - controller running flag
//            finish     - controller finish pulse, triggers the compare
//            scan_out   - SCAN_W parallel scan-chain outputs from the CUT
//            signature  - current MISR contents
//            cycle_cnt  - compaction cycles since last init (saturating)
//            busy       - high while armed
//            result_vld - high while a verdict is held
//            pass/fail  - verdict, valid while result_vld (mutually exclusive)
// Revision : 1.0 - initial release
// ============================================================================
module bist_signature_analyzer #(
  parameter int               WIDTH   = 16,
  parameter int               SCAN_W  = 1,
  parameter logic [WIDTH-1:0] POLY    = 16'h1021,
  parameter logic [WIDTH-1:0] SEED    = '0,
  parameter logic [WIDTH-1:0] GOLDEN  = '0,
  parameter int               EXP_CYC = 0,
  parameter int               CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init,
  input  logic              mode,
  input  logic              running,
  input  logic              finish,
  input  logic [SCAN_W-1:0] scan_out,
  output logic [WIDTH-1:0]  signature,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              busy,
  output logic              result_vld,
  output logic              pass,
  output logic              fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_exp_cyc   = CNT_W'(EXP_CYC);
  localparam bit               c_chk_count = (EXP_CYC != 0);

  state_t           r_state;
  logic [WIDTH-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_vld;
  logic             r_pass;
  logic             r_fail;

  logic [WIDTH-1:0] w_sig_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_match;

  // Galois-style MISR step: shift left, fold the outgoing MSB back through
  // the tap polynomial, then XOR in the parallel scan-out bits at the LSBs.
  assign w_sig_next = {r_sig[WIDTH-2:0], 1'b0}
                    ^ (r_sig[WIDTH-1] ? POLY : '0)
                    ^ WIDTH'(scan_out);

  // Saturate so that an overflowing run can never alias back onto EXP_CYC.
  assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  assign w_match = (r_sig == GOLDEN) && (!c_chk_count || (r_cnt == c_exp_cyc));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_vld   <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (init) begin
      // Init wins over finish and compaction; nothing is compacted this cycle.
      r_state <= ST_ARMED;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_vld   <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (finish) begin
            // Compare the registered values; scan_out this cycle is dropped.
            r_state <= ST_RESULT;
            r_busy  <= 1'b0;
            r_vld   <= 1'b1;
            r_pass  <= w_match;
            r_fail  <= !w_match;
          end else if (running && mode) begin
            r_sig <= w_sig_next;
            r_cnt <= w_cnt_next;
          end
        end
        // IDLE and RESULT ignore controller inputs and hold all outputs.
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign signature  = r_sig;
  assign cycle_cnt  = r_cnt;
  assign busy       = r_busy;
  assign result_vld = r_vld;
  assign pass       = r_pass;
  assign fail       = r_fail;

endmodule
`default_nettype wire
